// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller and memory.
// Latency: none, wires only.
// Backpressure: request held until imem_gnt; a single response via imem_rvalid.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: drives the PC register, issues one memory request at a time, holds the fetched word for decode.
// Latency: request granted in cycle N, data in N+1, instr_valid in N+2.
// Backpressure: stall keeps the held instruction and the PC; redirect/trap preempt stall and squash in-flight data.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc,
  output logic [31:0]        pc_next,
  fetch_ctrl_if.master       imem,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  input  logic               trap,
  output logic               instr_valid,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  output logic               misalign_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state;
  logic   discard;
  logic   req_q;
  logic   redir_hit;
  logic   target_misaligned;
  logic [31:0] redir_pc;

  // Redirects are only honoured once the fetch sequence has started
  assign redir_hit         = (state != IDLE) && (trap || redirect_valid);
  assign target_misaligned = (redirect_target[1:0] != 2'b00);
  assign redir_pc          = (trap || target_misaligned) ? TRAP_VEC : redirect_target;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;

  // Next-PC select: reset, then trap/redirect, then sequential advance on release of the held word
  always_comb begin
    pc_next        = pc;
    misalign_fault = 1'b0;
    if (reset) begin
      pc_next = RESET_PC;
    end else if (redir_hit) begin
      pc_next        = redir_pc;
      misalign_fault = !trap && redirect_valid && target_misaligned;
    end else if (state == HOLD && !stall) begin
      pc_next = pc + 32'd4;
    end
  end

  // Fetch FSM with registered request/valid outputs and captured instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      discard     <= 1'b0;
      req_q       <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: begin
          // Without a grant the request simply re-issues at the (possibly redirected) PC
          if (imem.imem_gnt) begin
            state   <= WAIT;
            req_q   <= 1'b0;
            discard <= redir_hit;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            if (discard || redir_hit) begin
              state   <= REQ;
              req_q   <= 1'b1;
              discard <= 1'b0;
            end else begin
              state       <= HOLD;
              instr_valid <= 1'b1;
              instr       <= imem.imem_rdata;
              instr_pc    <= pc;
            end
          end else if (redir_hit) begin
            discard <= 1'b1;
          end
        end
        HOLD: begin
          if (redir_hit || !stall) begin
            state       <= REQ;
            req_q       <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal expectations, then randomized traffic.
// Latency: compares every cycle at negedge+1 against a transaction-level reference.
// Backpressure: memory grants only when idle and returns data one or more cycles after grant.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        stall, redirect_valid, trap;
  logic [31:0] redirect_target;
  logic        instr_valid, misalign_fault;
  logic [31:0] instr, instr_pc;

  fetch_ctrl_if imem_bus ();

  fetch_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .pc_next         (pc_next),
    .imem            (imem_bus),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .misalign_fault  (misalign_fault)
  );

  always #5 clk = ~clk;

  // External PC register loaded from pc_next every edge
  always_ff @(posedge clk) pc <= pc_next;

  int checks = 0;
  int failures = 0;

  // Reference: transaction flags rather than a state machine encoding
  bit          m_starting, m_requesting, m_in_flight, m_squash, m_holding;
  logic [31:0] m_pc, m_instr, m_ipc;
  bit          mem_pending;

  // Values sampled at the last compare point, used by the literal checks
  logic [31:0] s_pc_next, s_addr, s_instr, s_ipc;
  logic        s_req, s_iv, s_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive inputs, compare, advance the reference, return at the next negedge
  task automatic step(input logic g, input logic rv, input logic [31:0] rd, input logic st,
                      input logic rdv, input logic [31:0] tgt, input logic tp);
    logic        act;
    logic [31:0] dest, e_pcn;
    logic        e_mis;
    imem_bus.imem_gnt    = g;
    imem_bus.imem_rvalid = rv;
    imem_bus.imem_rdata  = rd;
    stall                = st;
    redirect_valid       = rdv;
    redirect_target      = tgt;
    trap                 = tp;
    #1;
    act   = !m_starting && (tp || rdv);
    dest  = (tp || (tgt % 4 != 0)) ? TRAP_VEC : tgt;
    e_mis = act && !tp && rdv && (tgt % 4 != 0);
    if (act)                    e_pcn = dest;
    else if (m_holding && !st)  e_pcn = m_pc + 32'd4;
    else                        e_pcn = m_pc;
    chk("pc_next",        pc_next,               e_pcn);
    chk("imem_req",       {31'd0, imem_bus.imem_req}, {31'd0, m_requesting});
    chk("imem_addr",      imem_bus.imem_addr,    m_pc);
    chk("instr_valid",    {31'd0, instr_valid},  {31'd0, m_holding});
    chk("instr",          instr,                 m_instr);
    chk("instr_pc",       instr_pc,              m_ipc);
    chk("misalign_fault", {31'd0, misalign_fault}, {31'd0, e_mis});
    s_pc_next = pc_next;  s_addr = imem_bus.imem_addr; s_instr = instr; s_ipc = instr_pc;
    s_req = imem_bus.imem_req; s_iv = instr_valid; s_mis = misalign_fault;
    if (m_starting) begin
      m_starting   = 1'b0;
      m_requesting = 1'b1;
    end else if (m_requesting) begin
      if (g) begin
        m_requesting = 1'b0;
        m_in_flight  = 1'b1;
        m_squash     = act;
      end
    end else if (m_in_flight) begin
      if (rv) begin
        m_in_flight = 1'b0;
        if (m_squash || act) begin
          m_squash     = 1'b0;
          m_requesting = 1'b1;
        end else begin
          m_holding = 1'b1;
          m_instr   = rd;
          m_ipc     = m_pc;
        end
      end else if (act) begin
        m_squash = 1'b1;
      end
    end else if (m_holding) begin
      if (act || !st) begin
        m_holding    = 1'b0;
        m_requesting = 1'b1;
      end
    end
    m_pc = e_pcn;
    @(negedge clk);
  endtask

  // Called at a negedge: asynchronous reset checked before any clock edge, held over two edges
  task automatic do_reset();
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    redirect_valid       = 1'b1;
    redirect_target      = 32'h0000_0202;
    trap                 = 1'b0;
    stall                = 1'b0;
    reset                = 1'b1;
    #1;
    chk("rst_pc_next",     pc_next,                    RESET_PC);
    chk("rst_imem_req",    {31'd0, imem_bus.imem_req}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid},       32'd0);
    chk("rst_instr",       instr,                      32'd0);
    chk("rst_instr_pc",    instr_pc,                   32'd0);
    chk("rst_misalign",    {31'd0, misalign_fault},    32'd0);
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset        = 1'b0;
    m_starting   = 1'b1;
    m_requesting = 1'b0;
    m_in_flight  = 1'b0;
    m_squash     = 1'b0;
    m_holding    = 1'b0;
    m_instr      = 32'h0;
    m_ipc        = 32'h0;
    m_pc         = RESET_PC;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0; trap = 1'b0;
    imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = 32'h0;
    mem_pending = 1'b0;
    @(negedge clk);
    do_reset();

    // Back-to-back fetches with immediate grant and data
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 32'hC0DE_0000 | i, 1'b0, 1'b0, 32'h0, 1'b0);
      if (i == 3 || i == 6 || i == 9) begin
        chk("seq_iv",  {31'd0, s_iv}, 32'd1);
        chk("seq_ipc", s_ipc, (i / 3 - 1) * 4);
      end
      if (i == 1 || i == 4 || i == 7) chk("seq_addr", s_addr, ((i - 1) / 3) * 4);
      if (i == 3) chk("seq_instr", s_instr, 32'hC0DE_0002);
    end

    // Stall while holding
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'hBEEF_0001, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("stall_instr",   s_instr, 32'hBEEF_0001);
      chk("stall_ipc",     s_ipc, 32'h0000_000C);
      chk("stall_pc_next", s_pc_next, 32'h0000_000C);
      chk("stall_req",     {31'd0, s_req}, 32'd0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("unstall_pc_next", s_pc_next, 32'h0000_0010);

    // Redirect while waiting for data
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
    chk("redir_pc_next", s_pc_next, 32'h0000_0200);
    step(1'b0, 1'b1, 32'hDEAD_DEAD, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir_drop_iv", {31'd0, s_iv}, 32'd0);
    chk("redir_addr",    s_addr, 32'h0000_0200);

    // Trap beats redirect
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0300, 1'b1);
    chk("trap_pc_next", s_pc_next, 32'h0000_0100);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("trap_addr", s_addr, 32'h0000_0100);
    step(1'b0, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0, 1'b0);

    // Misaligned redirect from HOLD under stall
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0202, 1'b0);
    chk("mis_pulse",   {31'd0, s_mis}, 32'd1);
    chk("mis_pc_next", s_pc_next, 32'h0000_0100);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("mis_clear", {31'd0, s_mis}, 32'd0);
    chk("mis_addr",  s_addr, 32'h0000_0100);
    chk("mis_iv",    {31'd0, s_iv}, 32'd0);

    // PC wrap at the top of the address space
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 32'hAAAA_5555, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_pc_next", s_pc_next, 32'h0000_0000);
    chk("wrap_ipc",     s_ipc, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr", s_addr, 32'h0000_0000);

    // Reset while waiting, then stale data before the first grant
    do_reset();
    step(1'b0, 1'b1, 32'h5757_5757, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h5757_5757, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("stale_req",  {31'd0, s_req}, 32'd1);
    chk("stale_addr", s_addr, RESET_PC);
    chk("stale_iv",   {31'd0, s_iv}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0077, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("post_rst_iv",    {31'd0, s_iv}, 32'd1);
    chk("post_rst_instr", s_instr, 32'h0000_0077);
    chk("post_rst_ipc",   s_ipc, RESET_PC);

    // Randomized traffic with a well-behaved memory and occasional resets
    do_reset();
    mem_pending = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      logic        g, rv, st, rdv, tp;
      logic [31:0] tgt, rd;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        g   = imem_bus.imem_req && !mem_pending && ($urandom_range(0, 3) != 0);
        rv  = mem_pending && ($urandom_range(0, 2) != 0);
        rd  = $urandom;
        st  = ($urandom_range(0, 2) == 0);
        rdv = ($urandom_range(0, 9) == 0);
        tgt = ($urandom & 32'hFFFF_FFF0) |
              (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h0);
        tp  = ($urandom_range(0, 24) == 0);
        if (rv) mem_pending = 1'b0;
        if (g)  mem_pending = 1'b1;
        step(g, rv, rd, st, rdv, tgt, tp);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter TRAP_VEC, default 32'h0000_0100, address the PC jumps to on a trap.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 pc  in  32  current value from the PC register.
REQ-006 pc_next  out  32  value loaded into the PC register every clock edge.
REQ-007 imem_req  out  1  instruction-memory request valid.
REQ-008 imem_addr  out  32  request address; always equals pc.
REQ-009 imem_gnt  in  1  memory accepted the request this cycle.
REQ-010 imem_rvalid  in  1  read data valid this cycle.
REQ-011 imem_rdata  in  32  read data.
REQ-012 stall  in  1  decode cannot accept an instruction.
REQ-013 redirect_valid  in  1  taken branch or jump.
REQ-014 redirect_target  in  32  branch or jump target.
REQ-015 trap  in  1  exception request.
REQ-016 instr_valid, instr[31:0], instr_pc[31:0]  out  fetched instruction, its data and its address.
REQ-017 misalign_fault  out  1  one-cycle pulse when a redirect target has bits[1:0] != 0.

Function
REQ-018 The FSM SHALL have four states:
- IDLE: entered by reset; goes to REQ after one cycle.
- REQ: imem_req=1; goes to WAIT on imem_gnt.
- WAIT: waits for imem_rvalid; goes to HOLD when the instruction is kept, or to REQ when it is dropped.
- HOLD: instr_valid=1; goes to REQ when stall=0.
REQ-019 Default pc_next=pc (hold). In HOLD with stall=0, pc_next=pc+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-020 Redirect/trap priority: trap > redirect_valid > sequential.
- trap: pc_next=TRAP_VEC.
- redirect_valid with target[1:0]=0: pc_next=redirect_target.
- redirect_valid with target[1:0]!=0: pc_next=TRAP_VEC and misalign_fault=1.
REQ-021 Redirect or trap in REQ without grant: the PC updates, the FSM stays in REQ, and the new address is issued next cycle.
REQ-022 Redirect or trap in REQ with grant, or in WAIT: the PC updates and a discard flag is set; the matching rvalid is consumed without asserting instr_valid; the FSM then goes to REQ.
REQ-023 Redirect or trap in HOLD: the held instruction is dropped (instr_valid=0 next cycle), the PC updates and the FSM goes to REQ, regardless of stall.
REQ-024 Redirect or trap coincident with rvalid in WAIT: the data is dropped.
REQ-025 instr and instr_pc SHALL be captured on the kept rvalid and held stable throughout HOLD.
REQ-026 Fetch latency: the address in REQ with gnt at cycle N, and rvalid at N+1, gives instr_valid at N+2.
REQ-027 imem_req SHALL be 0 in IDLE, WAIT and HOLD; at most one request is outstanding.
REQ-028 Redirect/trap inputs in IDLE SHALL be ignored.

Reset
REQ-029 Reset asserted SHALL force: IDLE, pc_next=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, misalign_fault=0, discard flag cleared.
REQ-030 Reset mid-fetch SHALL abandon the outstanding request; any rvalid arriving before the first post-reset grant SHALL be ignored.
REQ-031 Outputs SHALL change within the reset-assertion cycle without a clock edge.

Verification
REQ-032 Reset release, gnt and rvalid immediate, stall=0 -> fetches at 0x0, 0x4, 0x8; instr_valid once every 3 cycles with matching instr_pc.
REQ-033 stall=1 for 5 cycles in HOLD -> instr and instr_pc unchanged, pc held, no imem_req; then stall=0 -> pc advances by 4.
REQ-034 redirect_valid to 0x200 during WAIT -> the pending rvalid is dropped and the next imem_addr is 0x200.
REQ-035 trap and redirect_valid (0x300) in the same cycle -> pc_next=0x100 and no fetch from 0x300.
REQ-036 redirect_target=0x202 -> misalign_fault pulses for 1 cycle and the next fetch is from 0x100.
REQ-037 pc=0xFFFF_FFFC, instruction accepted -> next fetch from 0x0; reset during WAIT followed by a stale rvalid -> no instr_valid and first fetch at RESET_PC.
